// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation sequencer:
// operand-mux select codes and the FSM state encoding.
package rsa_pkg;

    localparam logic [1:0] SEL_ACC  = 2'b00;
    localparam logic [1:0] SEL_BASE = 2'b01;
    localparam logic [1:0] SEL_ONE  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_SCAN   = 4'd2,
        ST_SQ     = 4'd3,
        ST_SQ_W   = 4'd4,
        ST_MUL    = 4'd5,
        ST_MUL_W  = 4'd6,
        ST_NEXT   = 4'd7,
        ST_POST   = 4'd8,
        ST_POST_W = 4'd9,
        ST_DONE   = 4'd10
    } state_t;

endpackage

// File: rtl/rsa_exp_shifter.sv
// Exponent shift register (MSB first) plus bit-index down-counter.
// o_bit is the bit currently being processed, o_last flags index 0.
// With RSA_SKIP_LEADING_ZEROS_EN defined, o_next_bit exposes the bit that
// becomes current after one shift, so the scan can stop on the first 1.
module rsa_exp_shifter
    import rsa_pkg::*;
#(
    parameter int EXP_WIDTH = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic [EXP_WIDTH-1:0] i_exponent,
    output logic                 o_bit,
`ifdef RSA_SKIP_LEADING_ZEROS_EN
    output logic                 o_next_bit,
`endif
    output logic                 o_last
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    logic [EXP_WIDTH-1:0] r_shreg;
    logic [EXP_WIDTH-1:0] w_shreg_shifted;
    logic [IDX_W-1:0]     r_idx;

    assign w_shreg_shifted = r_shreg << 1;

    // Load on accepted start, shift left and count the index down per bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shreg <= i_exponent;
            r_idx   <= IDX_W'(EXP_WIDTH - 1);
        end else if (i_shift) begin
            r_shreg <= w_shreg_shifted;
            if (r_idx != '0) begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign o_bit  = r_shreg[EXP_WIDTH-1];
    assign o_last = (r_idx == '0);
`ifdef RSA_SKIP_LEADING_ZEROS_EN
    assign o_next_bit = w_shreg_shifted[EXP_WIDTH-1];
`endif

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Left-to-right square-and-multiply control sequencer for a Montgomery
// multiplier. Drives operand-mux selects, multiplier start/done handshake
// and accumulator write strobes; holds no datapath.
// Optional feature macro: RSA_SKIP_LEADING_ZEROS_EN (skip leading zero bits
// of the exponent in a SCAN state before the first square).
//
// state  | meaning
// IDLE   | waiting for start, exponent latched on accept
// LOAD   | accumulator <= one
// SCAN   | skip one leading zero bit per cycle (macro builds only)
// SQ     | launch acc*acc
// SQ_W   | wait for square result, capture it
// MUL    | launch acc*base
// MUL_W  | wait for multiply result, capture it
// NEXT   | advance to next bit or finish
// POST   | launch acc*1 to leave the Montgomery domain
// POST_W | wait for post result, capture it
// DONE   | one-cycle completion pulse
module rsa_exp_sequencer
    import rsa_pkg::*;
#(
    parameter int EXP_WIDTH = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [EXP_WIDTH-1:0] i_exponent,
    input  logic                 i_mmm_done,
    output logic [1:0]           o_sel_a,
    output logic [1:0]           o_sel_b,
    output logic                 o_mmm_start,
    output logic                 o_acc_load,
    output logic                 o_acc_capture,
    output logic                 o_busy,
    output logic                 o_done
);

    state_t r_state;
    state_t w_state_next;
    logic   w_load;
    logic   w_shift;
    logic   w_bit;
    logic   w_last;
    logic   w_in_wait;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
    logic   w_next_bit;
`endif

    rsa_exp_shifter #(
        .EXP_WIDTH (EXP_WIDTH)
    ) u_shifter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_exponent (i_exponent),
        .o_bit      (w_bit),
`ifdef RSA_SKIP_LEADING_ZEROS_EN
        .o_next_bit (w_next_bit),
`endif
        .o_last     (w_last)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; outputs decode from the state register only.
    always_comb begin
        w_state_next = r_state;
        o_sel_a      = SEL_ZERO;
        o_sel_b      = SEL_ZERO;
        o_mmm_start  = 1'b0;
        o_acc_load   = 1'b0;
        o_done       = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_sel_a    = SEL_ONE;
                o_acc_load = 1'b1;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
                // MSB already set means there is nothing to skip.
                w_state_next = w_bit ? ST_SQ : ST_SCAN;
`else
                w_state_next = ST_SQ;
`endif
            end
`ifdef RSA_SKIP_LEADING_ZEROS_EN
            ST_SCAN: begin
                // Current bit is known zero here; peek at the following bit.
                if (w_last) begin
                    w_state_next = ST_POST;
                end else begin
                    w_shift      = 1'b1;
                    w_state_next = w_next_bit ? ST_SQ : ST_SCAN;
                end
            end
`endif
            ST_SQ: begin
                o_sel_a      = SEL_ACC;
                o_sel_b      = SEL_ACC;
                o_mmm_start  = 1'b1;
                w_state_next = ST_SQ_W;
            end
            ST_SQ_W: begin
                o_sel_a = SEL_ACC;
                o_sel_b = SEL_ACC;
                if (i_mmm_done) begin
                    w_state_next = w_bit ? ST_MUL : ST_NEXT;
                end
            end
            ST_MUL: begin
                o_sel_a      = SEL_ACC;
                o_sel_b      = SEL_BASE;
                o_mmm_start  = 1'b1;
                w_state_next = ST_MUL_W;
            end
            ST_MUL_W: begin
                o_sel_a = SEL_ACC;
                o_sel_b = SEL_BASE;
                if (i_mmm_done) begin
                    w_state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_last) begin
                    w_state_next = ST_POST;
                end else begin
                    w_shift      = 1'b1;
                    w_state_next = ST_SQ;
                end
            end
            ST_POST: begin
                o_sel_a      = SEL_ACC;
                o_sel_b      = SEL_ONE;
                o_mmm_start  = 1'b1;
                w_state_next = ST_POST_W;
            end
            ST_POST_W: begin
                o_sel_a = SEL_ACC;
                o_sel_b = SEL_ONE;
                if (i_mmm_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture strobe is the only output that looks at an input: a done pulse
    // outside the wait states must never write the accumulator.
    assign w_in_wait     = (r_state == ST_SQ_W) || (r_state == ST_MUL_W) ||
                           (r_state == ST_POST_W);
    assign o_acc_capture = w_in_wait & i_mmm_done;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Directed bench for rsa_exp_sequencer with a latency-programmable
// multiplier stand-in. Expected counts/cycle offsets are hand-computed for
// EXP_WIDTH=10; RSA_SKIP_LEADING_ZEROS_EN selects the matching table.
module tb_rsa_exp_sequencer;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] exponent;
    logic         mmm_done;
    logic [1:0]   sel_a, sel_b;
    logic         mmm_start, acc_load, acc_capture, busy, done;

    int errors = 0;
    int checks = 0;

    // multiplier model / monitor state
    int   cyc = 0;
    int   m_cnt = 0;
    logic m_done = 1'b0;
    logic spur = 1'b0;
    bit   spur_en = 1'b0;
    int   lat_mode = 1;      // 1: fixed latency, 0: cycle through lat_tab
    int   lat_fixed = 1;
    int   lat_tab[3] = '{1, 3, 7};
    int   run_base = 0;
    int   cur_lat = 1;
    logic start_seen = 1'b0;
    int   n_start = 0, n_cap = 0, n_load = 0, n_done = 0;
    int   load_cyc = 0, last_cap_cyc = 0, done_cyc = 0;
    int   sel_viol = 0;
    logic in_wait = 1'b0;
    logic [1:0] hold_a = 2'b11, hold_b = 2'b11;
    logic [3:0] ops[0:511];
    int   st_cyc[0:511];

    assign mmm_done = m_done | spur;

    always #5 clk = ~clk;

    rsa_exp_sequencer #(.EXP_WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_exponent    (exponent),
        .i_mmm_done    (mmm_done),
        .o_sel_a       (sel_a),
        .o_sel_b       (sel_b),
        .o_mmm_start   (mmm_start),
        .o_acc_load    (acc_load),
        .o_acc_capture (acc_capture),
        .o_busy        (busy),
        .o_done        (done)
    );

    // monitor: samples mid-cycle
    always @(negedge clk) begin
        cyc++;
        start_seen = mmm_start;
        if (mmm_start) begin
            ops[n_start]    = {sel_a, sel_b};
            st_cyc[n_start] = cyc;
            cur_lat = (lat_mode == 0) ? lat_tab[(n_start - run_base) % 3] : lat_fixed;
            n_start++;
            hold_a  = sel_a;
            hold_b  = sel_b;
            in_wait = 1'b1;
        end else if (in_wait && (sel_a !== hold_a || sel_b !== hold_b)) begin
            sel_viol++;
        end
        if (acc_capture) begin
            n_cap++;
            last_cap_cyc = cyc;
            in_wait = 1'b0;
        end
        if (acc_load) begin
            n_load++;
            load_cyc = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (rst) in_wait = 1'b0;
    end

    // multiplier model: done exactly L cycles after the start cycle;
    // optional spurious done in idle-select busy states and in start cycles
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            spur   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end
            if (start_seen) begin
                m_cnt  = cur_lat - 1;
                m_done = (m_cnt == 0);
            end
            spur = spur_en && busy && ((sel_a == 2'b11 && !done) || mmm_start);
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Launch one exponentiation, optionally poke start mid-run, wait for done
    // and check counts and cycle offsets relative to the accept edge.
    task automatic run_chk(input string name, input logic [W-1:0] e,
                           input int e_starts, input int e_muls,
                           input int e_done_off, input int e_gap,
                           input bit poke);
        int s_start, s_cap, s_done, s_viol, c0, muls, alt_bad;
        bit got;
        s_start = n_start; s_cap = n_cap; s_done = n_done; s_viol = sel_viol;
        run_base = n_start;
        @(negedge clk); #1;
        start = 1'b1; exponent = e; c0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        if (poke) begin
            @(negedge clk); #1;
            @(negedge clk); #1;
            start = 1'b1; exponent = 10'h3FF;
            @(negedge clk); #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk); #1;
            if (n_done != s_done) got = 1'b1;
        end
        chk({name, "_timeout"}, int'(got), 1);
        chk({name, "_done_hi"}, int'(done), 1);
        chk({name, "_busy_hi"}, int'(busy), 1);
        @(negedge clk); #1;
        chk({name, "_busy_lo"}, int'(busy), 0);
        chk({name, "_starts"}, n_start - s_start, e_starts);
        chk({name, "_caps"}, n_cap - s_cap, e_starts);
        muls = 0; alt_bad = 0;
        for (int i = s_start; i < n_start; i++) if (ops[i] == 4'b0001) muls++;
        chk({name, "_muls"}, muls, e_muls);
        chk({name, "_post_sel"}, int'(ops[n_start-1]), 2);
        chk({name, "_done_off"}, done_cyc - c0, e_done_off);
        chk({name, "_cap2done"}, done_cyc - last_cap_cyc, 1);
        chk({name, "_load_off"}, load_cyc - c0, 1);
        chk({name, "_gap"}, st_cyc[s_start] - load_cyc, e_gap);
        chk({name, "_sel_hold"}, sel_viol - s_viol, 0);
        if (e == 10'h3FF) begin
            for (int i = 0; i < 20; i++)
                if (ops[s_start+i] != ((i % 2) ? 4'b0001 : 4'b0000)) alt_bad++;
            chk({name, "_alternate"}, alt_bad, 0);
        end
    endtask

    initial begin
        int s;
        bit got;
        rst = 1'b1; start = 1'b0; exponent = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sel_a", int'(sel_a), 3);
        chk("rst_sel_b", int'(sel_b), 3);
        chk("rst_mmm_start", int'(mmm_start), 0);
        chk("rst_acc_load", int'(acc_load), 0);
        chk("rst_acc_capture", int'(acc_capture), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        lat_mode = 1; lat_fixed = 1;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
        run_chk("e5_l1", 10'b0000000101, 6, 2, 24, 8, 1'b0);
        run_chk("e0_l1", 10'b0000000000, 1, 0, 14, 11, 1'b0);
`else
        run_chk("e5_l1", 10'b0000000101, 13, 2, 38, 1, 1'b0);
        run_chk("e0_l1", 10'b0000000000, 11, 0, 34, 1, 1'b0);
`endif

        lat_fixed = 3; spur_en = 1'b1;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
        run_chk("e5_poke", 10'b0000000101, 6, 2, 36, 8, 1'b1);
`else
        run_chk("e5_poke", 10'b0000000101, 13, 2, 64, 1, 1'b1);
`endif
        spur_en = 1'b0;

        lat_mode = 0;
        run_chk("e3ff_var", 10'h3FF, 21, 10, 110, 1, 1'b0);

        // asynchronous reset in the capture cycle of the first MUL_W
        lat_mode = 1; lat_fixed = 7;
        s = n_start;
        @(negedge clk); #1;
        start = 1'b1; exponent = 10'h3FF;
        @(negedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); #1;
            if ((n_start - s) >= 2 && mmm_done === 1'b1) got = 1'b1;
        end
        chk("mrst_reach", int'(got), 1);
        chk("mrst_pre_cap", int'(acc_capture), 1);
        chk("mrst_pre_selb", int'(sel_b), 1);
        rst = 1'b1;
        #1;
        chk("mrst_sel_a", int'(sel_a), 3);
        chk("mrst_sel_b", int'(sel_b), 3);
        chk("mrst_mmm_start", int'(mmm_start), 0);
        chk("mrst_acc_load", int'(acc_load), 0);
        chk("mrst_acc_capture", int'(acc_capture), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        lat_fixed = 1;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
        run_chk("after_rst", 10'b0000000101, 6, 2, 24, 8, 1'b0);
`else
        run_chk("after_rst", 10'b0000000101, 13, 2, 38, 1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_exp_sequencer.md
# rsa_exp_sequencer

Control sequencer for modular exponentiation (left-to-right square-and-multiply). It drives the 2-bit select codes of the two operand muxes that feed the Montgomery multiplier, and handshakes with the multiplier through start/done. It also issues the accumulator write strobes. It holds no datapath and sits between the top-level command interface and the multiplier/mux datapath.

## Interface
- `EXP_WIDTH`, default 10: exponent width in bits; must match the datapath width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request exponentiation; sampled only in IDLE.
- `exponent`  in  EXP_WIDTH  exponent; latched on the accepted `start`.
- `mmm_done`  in  1  multiplier result-valid pulse, one cycle.
- `sel_a`  out  2  operand-A mux select: 00 accumulator, 01 base, 10 constant one, 11 zero.
- `sel_b`  out  2  operand-B mux select, same encoding as `sel_a`.
- `mmm_start`  out  1  one-cycle multiplier launch pulse.
- `acc_load`  out  1  accumulator <= operand-A mux output.
- `acc_capture`  out  1  accumulator <= multiplier result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: `start`=1 latches `exponent` into the shift register, sets bit index = EXP_WIDTH-1, and goes to LOAD.
  - LOAD: `sel_a`=10 and `acc_load`=1. The accumulator takes the value one. Next state is SQ, or SCAN if the macro is defined.
  - SQ: `sel_a`=`sel_b`=00 and `mmm_start`=1. Next state is SQ_W.
  - SQ_W: hold sels. On `mmm_done`, assert `acc_capture`. Go to MUL if the current bit is 1, else to NEXT.
  - MUL: `sel_a`=00, `sel_b`=01, `mmm_start`=1. Next state is MUL_W.
  - MUL_W: hold sels. On `mmm_done`, assert `acc_capture` and go to NEXT.
  - NEXT: if index=0, go to POST. Otherwise decrement index, shift left, and go to SQ.
  - POST: `sel_a`=00, `sel_b`=10, `mmm_start`=1. This multiplies by one to leave the Montgomery domain. Next state is POST_W.
  - POST_W: on `mmm_done`, assert `acc_capture` and go to DONE.
  - DONE: `done`=1, then go to IDLE.
- Output decoding:
  - All outputs except `acc_capture` decode from the state register only.
  - `acc_capture` = (state in *_W) & `mmm_done`.
- Sels are 11 (zero) in IDLE, NEXT, DONE and SCAN.
- Multiplier operation counts: EXP_WIDTH squares, popcount(exponent) multiplies, 1 post.
- Boundary conditions:
  - `start` outside IDLE: ignored; `exponent` is not re-latched.
  - `mmm_done` outside the *_W states: ignored and produces no `acc_capture`.
  - `mmm_done` in the same cycle as `mmm_start`: ignored, because the state is not yet *_W.
  - exponent=0, macro undefined: EXP_WIDTH squares of one, then POST.
  - `rst` asserted mid-operation: immediate return to IDLE with all outputs at reset values. The multiplier is not notified.

## Timing
- Reset values:
  - state IDLE
  - `sel_a`=`sel_b`=11
  - `mmm_start`=`acc_load`=`acc_capture`=`busy`=`done`=0
  - index and shift register 0
- `start` is accepted at edge k.
  - LOAD runs in cycle k+1.
  - The first `mmm_start` is in cycle k+2.
- A multiplier with done latency L (done L cycles after the start cycle, L≥1):
  - SQ/MUL/POST occupy 1 cycle.
  - *_W occupies L cycles.
  - NEXT occupies 1 cycle.
- `done` follows the final `acc_capture` by exactly 1 cycle. `busy` falls in the cycle after `done`.

## Configuration
- Macro `RSA_SKIP_LEADING_ZEROS_EN`.
- Defined: LOAD goes to the SCAN state.
  - SCAN consumes one cycle per leading zero bit, issues no operation, and decrements the index.
  - On the first 1 bit it goes to SQ.
  - If the index reaches 0 with no 1 bit found, it goes to POST.
- Undefined: the SCAN state and its logic are absent, and all EXP_WIDTH bits are processed.

## Structure
- `rsa_pkg` holds:
  - select codes SEL_ACC=2'b00, SEL_BASE=2'b01, SEL_ONE=2'b10, SEL_ZERO=2'b11
  - the state encoding constants
- Sub-module `rsa_exp_shifter` holds the exponent shift register and the bit-index down-counter.
  - Inputs: load, shift.
  - Outputs: current bit, last-bit flag.
- The FSM stays in `rsa_exp_sequencer`.

## Test plan
- Reset mid-MUL_W -> all outputs return to their reset values in the same cycle (asynchronous). After `rst` falls, the block is idle and accepts a new `start`.
- exponent=10'b0000000101, L=1, macro undefined -> 13 `mmm_start` pulses (10 SQ, MUL after bit 2 and bit 0, 1 POST), 13 `acc_capture` pulses, and `done` 1 cycle after the last capture.
- Same exponent, macro defined -> 7 SCAN cycles, then 3 SQ, 2 MUL, 1 POST (6 launches).
- exponent=0, macro defined -> LOAD, 10 SCAN cycles, POST only (1 launch), then `done`.
- `start` pulsed during SQ_W, and a spurious `mmm_done` in NEXT -> no re-latch, no extra `acc_capture`, and the total operation count is unchanged.
- Variable L (1, 3, 7 per operation) on exponent=10'b1111111111 -> 10 SQ and 10 MUL strictly alternating. The sels are held stable throughout every *_W state.
